// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit stack processor: opcodes, ALU ops, control states,
// ALU B-source selects and the control-strobe bundle.
package cpu_pkg;

  // Instruction opcodes (IR[7:5])
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  // ALU operation select, shared with the ALU
  localparam logic [2:0] ADD_OP    = 3'b000;
  localparam logic [2:0] SUB_OP    = 3'b001;
  localparam logic [2:0] AND_OP    = 3'b010;
  localparam logic [2:0] NOT_OP    = 3'b011;
  localparam logic [2:0] ISZERO_OP = 3'b100;

  // Control FSM state encodings
  localparam logic [3:0] S_IF       = 4'd0;
  localparam logic [3:0] S_ID       = 4'd1;
  localparam logic [3:0] S_POP_A    = 4'd2;
  localparam logic [3:0] S_POP_B    = 4'd3;
  localparam logic [3:0] S_EXEC     = 4'd4;
  localparam logic [3:0] S_PUSH_RES = 4'd5;
  localparam logic [3:0] S_PUSH_MEM = 4'd6;
  localparam logic [3:0] S_PUSH_MDR = 4'd7;
  localparam logic [3:0] S_POP_ST   = 4'd8;
  localparam logic [3:0] S_POP_WR   = 4'd9;
  localparam logic [3:0] S_JMP      = 4'd10;
  localparam logic [3:0] S_JZ_TOS   = 4'd11;
  localparam logic [3:0] S_JZ_CHK   = 4'd12;

  // ALU B-input select codes
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_ONE  = 2'b01;
  localparam logic [1:0] SRC_B_ZERO = 2'b10;

  // Full set of datapath controls produced per cycle
  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       a_write;
    logic       b_write;
    logic       aluout_write;
    logic       stack_push;
    logic       stack_pop;
    logic       stack_tos;
    logic       stack_src;
  } ctrl_t;

endpackage

// File: rtl/stack_cpu_out_decode.sv
// Combinational state-to-control decoder for the stack CPU FSM. Moore outputs except
// pc_write in JZ_CHK, which follows the ALU zero flag.
module stack_cpu_out_decode
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 3,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                rst,
  input  logic [STATE_W-1:0]  state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output ctrl_t               ctrl
);

  // Decode the current state into strobes; everything is held low during reset
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        S_IF: begin
          ctrl.mem_read  = 1'b1;
          ctrl.ir_write  = 1'b1;
          ctrl.alu_src_b = SRC_B_ONE;
          ctrl.alu_ctrl  = ADD_OP;
          ctrl.pc_write  = 1'b1;
        end
        S_POP_A: begin
          ctrl.stack_pop = 1'b1;
          ctrl.a_write   = 1'b1;
        end
        S_POP_B: begin
          ctrl.stack_pop = 1'b1;
          ctrl.b_write   = 1'b1;
        end
        S_EXEC: begin
          ctrl.alu_src_a    = 1'b1;
          ctrl.alu_src_b    = SRC_B_REG;
          ctrl.alu_ctrl     = opcode;
          ctrl.aluout_write = 1'b1;
        end
        S_PUSH_RES: begin
          ctrl.stack_push = 1'b1;
          ctrl.stack_src  = 1'b1;
        end
        S_PUSH_MEM: begin
          ctrl.mem_read  = 1'b1;
          ctrl.iord      = 1'b1;
          ctrl.mdr_write = 1'b1;
        end
        S_PUSH_MDR: begin
          ctrl.stack_push = 1'b1;
        end
        S_POP_ST: begin
          ctrl.stack_pop = 1'b1;
          ctrl.a_write   = 1'b1;
        end
        S_POP_WR: begin
          // Write data comes from A, loaded in POP_ST
          ctrl.mem_write = 1'b1;
          ctrl.iord      = 1'b1;
        end
        S_JMP: begin
          ctrl.pc_src   = 1'b1;
          ctrl.pc_write = 1'b1;
        end
        S_JZ_TOS: begin
          ctrl.stack_tos = 1'b1;
          ctrl.a_write   = 1'b1;
        end
        S_JZ_CHK: begin
          // ISZERO gives 1 when A==0, so zero==0 means the branch is taken
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_ctrl  = ISZERO_OP;
          ctrl.pc_src    = 1'b1;
          ctrl.pc_write  = ~zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stack_cpu_controller.sv
// Multicycle control FSM for the 8-bit stack processor: state register, next-state
// logic and the output decoder instance.
module stack_cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 3,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic [2:0]          ALUcontrol,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                pc_write,
  output logic                pc_src,
  output logic                IorD,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mdr_write,
  output logic                a_write,
  output logic                b_write,
  output logic                aluout_write,
  output logic                stack_push,
  output logic                stack_pop,
  output logic                stack_tos,
  output logic                stack_src,
  output logic [STATE_W-1:0]  state_o
);

  logic [STATE_W-1:0] state_q, state_d;
  ctrl_t              ctrl;

  // State register with synchronous reset to instruction fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing; unused encodings fall back to fetch
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_NOT: state_d = S_POP_A;
          OP_PUSH:                        state_d = S_PUSH_MEM;
          OP_POP:                         state_d = S_POP_ST;
          OP_JMP:                         state_d = S_JMP;
          default:                        state_d = S_JZ_TOS;
        endcase
      end
      S_POP_A:    state_d = (opcode == OP_NOT) ? S_EXEC : S_POP_B;
      S_POP_B:    state_d = S_EXEC;
      S_EXEC:     state_d = S_PUSH_RES;
      S_PUSH_RES: state_d = S_IF;
      S_PUSH_MEM: state_d = S_PUSH_MDR;
      S_PUSH_MDR: state_d = S_IF;
      S_POP_ST:   state_d = S_POP_WR;
      S_POP_WR:   state_d = S_IF;
      S_JMP:      state_d = S_IF;
      S_JZ_TOS:   state_d = S_JZ_CHK;
      S_JZ_CHK:   state_d = S_IF;
      default:    state_d = S_IF;
    endcase
  end

  stack_cpu_out_decode #(
    .OPCODE_W (OPCODE_W),
    .STATE_W  (STATE_W)
  ) u_out_decode (
    .rst    (rst),
    .state  (state_q),
    .opcode (opcode),
    .zero   (zero),
    .ctrl   (ctrl)
  );

  // Unpack the control bundle onto the datapath-facing ports
  always_comb begin
    ALUcontrol   = ctrl.alu_ctrl;
    alu_src_a    = ctrl.alu_src_a;
    alu_src_b    = ctrl.alu_src_b;
    pc_write     = ctrl.pc_write;
    pc_src       = ctrl.pc_src;
    IorD         = ctrl.iord;
    mem_read     = ctrl.mem_read;
    mem_write    = ctrl.mem_write;
    ir_write     = ctrl.ir_write;
    mdr_write    = ctrl.mdr_write;
    a_write      = ctrl.a_write;
    b_write      = ctrl.b_write;
    aluout_write = ctrl.aluout_write;
    stack_push   = ctrl.stack_push;
    stack_pop    = ctrl.stack_pop;
    stack_tos    = ctrl.stack_tos;
    stack_src    = ctrl.stack_src;
    state_o      = state_q;
  end

endmodule
